// File: rtl/lifo_stack.sv
// Parametrised synchronous LIFO stack with top-of-stack peek, registered pop
// output, simultaneous push/pop (replace or pass-through) and sticky error flags.
module lifo_stack #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 256,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  input  logic              clr_err,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [DATA_W-1:0] top,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] top_q, top_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic              is_empty, is_full;
  logic [CNT_W-1:0]  cnt_m1, cnt_m2;
  logic [DATA_W-1:0] refill;
  logic              wr_en;
  logic [AW-1:0]     wr_idx;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_W'(DEPTH));
  assign cnt_m1   = count_q - CNT_W'(1);
  assign cnt_m2   = count_q - CNT_W'(2);

  // Entry below the current top; only consumed when count >= 2.
  assign refill   = mem_q[cnt_m2[AW-1:0]];

  always_comb begin
    count_d      = count_q;
    top_d        = top_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;
    wr_en        = 1'b0;
    wr_idx       = count_q[AW-1:0];

    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end

    case ({push, pop})
      2'b10: begin
        if (is_full) begin
          overflow_d = 1'b1;
        end else begin
          wr_en   = 1'b1;
          count_d = count_q + CNT_W'(1);
          top_d   = din;
        end
      end
      2'b01: begin
        if (is_empty) begin
          underflow_d = 1'b1;
        end else begin
          dout_d       = top_q;
          dout_valid_d = 1'b1;
          count_d      = cnt_m1;
          top_d        = (count_q == CNT_W'(1)) ? '0 : refill;
        end
      end
      2'b11: begin
        dout_valid_d = 1'b1;
        if (is_empty) begin
          // Pass-through: nothing is stored, din goes straight out.
          dout_d = din;
        end else begin
          dout_d = top_q;
          wr_en  = 1'b1;
          wr_idx = cnt_m1[AW-1:0];
          top_d  = din;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q      <= '0;
      top_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      count_q      <= count_d;
      top_q        <= top_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Storage is never cleared; entries at or above count are simply ignored.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem_q[wr_idx] <= din;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign top        = top_q;
  assign count      = count_q;
  assign empty      = is_empty;
  assign full       = is_full;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_lifo_stack.sv
// Self-checking bench: two stack instances (8x4 and 16x5) driven by directed
// and random stimulus, compared against queue-based reference models.
module tb_lifo_stack;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: DATA_W=8, DEPTH=4
  logic       reset_a, push_a, pop_a, clr_a;
  logic [7:0] din_a, dout_a, top_a;
  logic [2:0] count_a;
  logic       dv_a, empty_a, full_a, ovf_a, udf_a;

  // Instance B: DATA_W=16, DEPTH=5
  logic        reset_b, push_b, pop_b, clr_b;
  logic [15:0] din_b, dout_b, top_b;
  logic [2:0]  count_b;
  logic        dv_b, empty_b, full_b, ovf_b, udf_b;

  lifo_stack #(.DATA_W(8), .DEPTH(4)) u_dut_a (
    .clk(clk), .reset(reset_a), .push(push_a), .pop(pop_a), .din(din_a),
    .clr_err(clr_a), .dout(dout_a), .dout_valid(dv_a), .top(top_a),
    .count(count_a), .empty(empty_a), .full(full_a),
    .overflow(ovf_a), .underflow(udf_a)
  );

  lifo_stack #(.DATA_W(16), .DEPTH(5)) u_dut_b (
    .clk(clk), .reset(reset_b), .push(push_b), .pop(pop_b), .din(din_b),
    .clr_err(clr_b), .dout(dout_b), .dout_valid(dv_b), .top(top_b),
    .count(count_b), .empty(empty_b), .full(full_b),
    .overflow(ovf_b), .underflow(udf_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [15:0] stk_a[$];
  logic [15:0] stk_b[$];
  logic [15:0] e_dout [2];
  bit          e_dv   [2];
  bit          e_ovf  [2];
  bit          e_udf  [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input int w, input bit rst, input bit ps, input bit pp,
                            input logic [15:0] d_in, input bit clr);
    logic [15:0] q[$];
    logic [15:0] d;
    int depth;
    bit set_o, set_u;
    if (w == 0) begin q = stk_a; depth = 4; d = d_in & 16'h00FF; end
    else        begin q = stk_b; depth = 5; d = d_in; end
    set_o = 1'b0;
    set_u = 1'b0;
    if (rst) begin
      q.delete();
      e_dout[w] = '0; e_dv[w] = 1'b0; e_ovf[w] = 1'b0; e_udf[w] = 1'b0;
    end else begin
      e_dv[w] = 1'b0;
      if (ps && pp) begin
        e_dv[w] = 1'b1;
        if (q.size() == 0) e_dout[w] = d;
        else begin
          e_dout[w] = q.pop_back();
          q.push_back(d);
        end
      end else if (ps) begin
        if (q.size() < depth) q.push_back(d);
        else set_o = 1'b1;
      end else if (pp) begin
        if (q.size() > 0) begin
          e_dout[w] = q.pop_back();
          e_dv[w] = 1'b1;
        end else set_u = 1'b1;
      end
      if (clr) begin e_ovf[w] = 1'b0; e_udf[w] = 1'b0; end
      if (set_o) e_ovf[w] = 1'b1;
      if (set_u) e_udf[w] = 1'b1;
    end
    if (w == 0) stk_a = q; else stk_b = q;
  endtask

  task automatic check_all(input int w);
    logic [15:0] q[$];
    logic [15:0] e_top;
    if (w == 0) q = stk_a; else q = stk_b;
    e_top = (q.size() > 0) ? q[q.size()-1] : 16'h0;
    if (w == 0) begin
      check("A.count", 32'(count_a), 32'(q.size()));
      check("A.top",   32'(top_a),   32'(e_top));
      check("A.empty", 32'(empty_a), 32'(q.size() == 0));
      check("A.full",  32'(full_a),  32'(q.size() == 4));
      check("A.dout",  32'(dout_a),  32'(e_dout[0]));
      check("A.dv",    32'(dv_a),    32'(e_dv[0]));
      check("A.ovf",   32'(ovf_a),   32'(e_ovf[0]));
      check("A.udf",   32'(udf_a),   32'(e_udf[0]));
    end else begin
      check("B.count", 32'(count_b), 32'(q.size()));
      check("B.top",   32'(top_b),   32'(e_top));
      check("B.empty", 32'(empty_b), 32'(q.size() == 0));
      check("B.full",  32'(full_b),  32'(q.size() == 5));
      check("B.dout",  32'(dout_b),  32'(e_dout[1]));
      check("B.dv",    32'(dv_b),    32'(e_dv[1]));
      check("B.ovf",   32'(ovf_b),   32'(e_ovf[1]));
      check("B.udf",   32'(udf_b),   32'(e_udf[1]));
    end
  endtask

  task automatic step(input bit ra, input bit psa, input bit ppa, input logic [7:0] da, input bit ca,
                      input bit rb, input bit psb, input bit ppb, input logic [15:0] db, input bit cb);
    reset_a = ra; push_a = psa; pop_a = ppa; din_a = da; clr_a = ca;
    reset_b = rb; push_b = psb; pop_b = ppb; din_b = db; clr_b = cb;
    @(posedge clk);
    model_step(0, ra, psa, ppa, {8'h00, da}, ca);
    model_step(1, rb, psb, ppb, db, cb);
    #1;
    $display("t=%0t A r%0b u%0b o%0b c%0b d=%h cnt=%0d top=%h dout=%h v=%0b | B r%0b u%0b o%0b c%0b d=%h cnt=%0d top=%h dout=%h v=%0b",
             $time, ra, psa, ppa, ca, da, count_a, top_a, dout_a, dv_a,
             rb, psb, ppb, cb, db, count_b, top_b, dout_b, dv_b);
    check_all(0);
    check_all(1);
  endtask

  task automatic op_a(input bit rst, input bit ps, input bit pp, input logic [7:0] d, input bit clr);
    step(rst, ps, pp, d, clr, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic op_b(input bit ps, input bit pp, input logic [15:0] d);
    step(1'b0, 1'b0, 1'b0, 8'h0, 1'b0, 1'b0, ps, pp, d, 1'b0);
  endtask

  initial begin
    reset_a = 1'b0; push_a = 1'b0; pop_a = 1'b0; din_a = '0; clr_a = 1'b0;
    reset_b = 1'b0; push_b = 1'b0; pop_b = 1'b0; din_b = '0; clr_b = 1'b0;

    step(1'b1, 1'b0, 1'b0, 8'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);

    // Fill, overflow, drain, underflow, clear
    op_a(0, 1, 0, 8'h11, 0);
    op_a(0, 1, 0, 8'h22, 0);
    op_a(0, 1, 0, 8'h33, 0);
    op_a(0, 1, 0, 8'h44, 0);
    op_a(0, 1, 0, 8'h55, 0);
    for (int i = 0; i < 4; i++) op_a(0, 0, 1, 8'h00, 0);
    op_a(0, 0, 1, 8'h00, 0);
    op_a(0, 0, 0, 8'h00, 1);

    // Replace and pass-through
    op_a(0, 1, 0, 8'h11, 0);
    op_a(0, 1, 0, 8'h22, 0);
    op_a(0, 1, 1, 8'h99, 0);
    op_a(0, 0, 1, 8'h00, 0);
    op_a(0, 0, 1, 8'h00, 0);
    op_a(0, 1, 1, 8'hAB, 0);

    // Reset mid-operation wins over push
    op_a(0, 1, 0, 8'h01, 0);
    op_a(0, 1, 0, 8'h02, 0);
    op_a(0, 1, 0, 8'h03, 0);
    op_a(1, 1, 0, 8'h77, 0);
    op_a(0, 0, 1, 8'h00, 0);
    op_a(0, 1, 0, 8'h00, 1);

    // Non-power-of-two depth, wide data
    for (int i = 0; i < 5; i++) op_b(1, 0, 16'hA000 + 16'(i * 16'h0111));
    op_b(1, 0, 16'hBEEF);
    for (int i = 0; i < 5; i++) op_b(0, 1, 16'h0);

    // Random traffic on both instances together
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
           8'($urandom), $urandom_range(0, 99) < 5,
           $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
           16'($urandom), $urandom_range(0, 99) < 5);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/lifo_stack.md
# lifo_stack

Parametrised synchronous LIFO stack. Generalises the team's fixed 8-bit × 256 stack RAM to configurable data width and depth. Adds full/empty/count status, a top-of-stack peek output, a registered pop output with a valid strobe, push-and-pop in the same cycle, and sticky overflow/underflow error flags. It sits between an instruction/expression datapath and its operand storage, and is the drop-in successor for every new stack instance.

## Interface
- DATA_W, 8, data word width in bits (≥1)
- DEPTH, 256, number of entries (≥2, power of two not required)
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived; not overridden)
- clk  input  1  single clock; all state changes on its rising edge
- reset  input  1  synchronous, active-high reset
- push  input  1  write din onto the stack this cycle
- pop  input  1  remove the top entry this cycle
- din  input  DATA_W  data to push
- clr_err  input  1  clears overflow/underflow flags (synchronous)
- dout  output  DATA_W  registered popped data; holds its value between pops
- dout_valid  output  1  one-cycle strobe: dout was updated by a successful pop
- top  output  DATA_W  current top-of-stack entry; 0 when empty
- count  output  CNT_W  number of stored entries, 0..DEPTH
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- overflow  output  1  sticky: a push was rejected because the stack was full
- underflow  output  1  sticky: a pop was rejected because the stack was empty

## Operation
- Storage: DEPTH×DATA_W array plus a stack pointer equal to count. Entry k (0-based from the bottom) is stored at index k. Array contents are not cleared on reset or on pop; reads beyond count are never exposed.
- The top output is driven from a dedicated register that always mirrors entry count-1, or 0 when empty. This keeps the peek free of array read latency.
- Each cycle is decoded from {push, pop}:
  - 00: no change; dout_valid=0.
  - 10, not full: write din at index count; count+=1; top←din.
  - 10, full: array, count and top are unchanged; overflow←1.
  - 01, not empty: dout←top; dout_valid=1; count−=1; top←entry count-2, or 0 if the stack becomes empty.
  - 01, empty: dout unchanged; dout_valid=0; underflow←1.
  - 11, not empty (full included): replace. dout←old top; dout_valid=1; din is written at index count-1; top←din; count unchanged. No error flags are set.
  - 11, empty: pass-through. dout←din; dout_valid=1; count stays 0; top stays 0. No error flags are set.
- Error flags: set as above. Cleared by reset or clr_err. If clr_err and a new error occur in the same cycle, the set wins.
- Status: empty and full are decoded from the count register.
- Arithmetic: count is unsigned CNT_W bits. Count never wraps: increments are blocked at DEPTH and decrements at 0.

## Timing
- Reset (reset=1 at a rising edge) forces count=0, top=0, dout=0, dout_valid=0, overflow=0 and underflow=0 on that edge. Reset overrides push, pop and clr_err in the same cycle. Asserting reset mid-sequence discards all stored entries logically.
- Pop latency: dout and dout_valid update on the edge that samples pop. dout_valid is high for exactly that one following cycle.
- Push latency: top, count, empty and full reflect a push on the edge that samples it. A pop in the next cycle returns the pushed value.
- Back-to-back pops are supported every cycle. Back-to-back pushes are supported every cycle.
- There is no ready/valid backpressure. Callers must gate push on !full and pop on !empty; violations are reported only through the error flags.
- Two-port array access: one write index and one read index (count-2 for top refill) per cycle, both combinational from count.

## Test plan
- Reset and fill (DEPTH=4, DATA_W=8): reset, then push 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> count 1,2,3,4; top 0x44; full=1; empty=0; overflow=0.
- Drain LIFO order: from the full state, pop ×4 back-to-back -> dout 0x44, 0x33, 0x22, 0x11 with dout_valid high each cycle; final count=0; empty=1; top=0.
- Overflow/underflow: with the stack full, push 0x55 -> count stays 4, top 0x44, overflow=1. Drain, then pop once more -> dout holds 0x11, dout_valid=0, underflow=1. Pulse clr_err -> both flags 0.
- Simultaneous push+pop: with stack [0x11, 0x22], push 0x99 + pop -> dout=0x22, dout_valid=1, count=2, top=0x99. On an empty stack, push 0xAB + pop -> dout=0xAB, count=0, no flags set.
- Reset mid-operation: with 3 entries, assert reset together with push 0x77 -> count=0, top=0, dout=0, flags 0. A following pop -> underflow=1, dout_valid=0.
- Parameter sweep: DATA_W=16, DEPTH=5 (non-power-of-two). Push 5 values -> full=1, count=5. The 6th push sets overflow, and all 5 values pop in reverse order.
